occ_read_arbiter: RTL and testbench

//  Round-robin arbiter sharing one AXI4-Lite read-only master port (Occ-table ROM/DDR) among NREQ

---
 rtl/occ_arb_pkg.sv | 34 +++
 rtl/occ_arb_id_fifo.sv | 56 +++++
 rtl/occ_read_arbiter.sv | 123 ++++++++++++
 tb/tb_occ_read_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/occ_arb_pkg.sv
// Shared types and the round-robin pick helper for the Occ-table read arbiter.
package occ_arb_pkg;

  localparam int unsigned OCC_NREQ = 4;
  localparam int unsigned NREQ_MAX = 16;
  localparam int unsigned IDW      = $clog2(OCC_NREQ);
  localparam int unsigned PICKW    = $clog2(NREQ_MAX);

  typedef logic [IDW-1:0] req_id_t;

  typedef struct packed {
    logic             found;
    logic [PICKW-1:0] idx;
  } rr_pick_t;

  // First asserted request at or after ptr, wrapping at nreq (ptr < nreq).
  function automatic rr_pick_t rr_pick(input logic [NREQ_MAX-1:0] req,
                                       input logic [PICKW-1:0]    ptr,
                                       input int unsigned         nreq);
    rr_pick_t    r;
    int unsigned idx;
    r = '0;
    for (int unsigned k = 0; k < NREQ_MAX; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= nreq) idx = idx - nreq;
      if (k < nreq && !r.found && idx < NREQ_MAX && req[idx[PICKW-1:0]]) begin
        r.found = 1'b1;
        r.idx   = PICKW'(idx);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/occ_arb_id_fifo.sv
// Synchronous FIFO of requester indices, one entry per accepted-but-unanswered read.
module occ_arb_id_fifo #(
  parameter int unsigned W     = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/occ_read_arbiter.sv
// Round-robin sharing of one AXI4-Lite read master among NREQ engines, in-order responses.
// Optional per-requester completion counters built when OCC_ARB_PERF_EN is defined.
module occ_read_arbiter
  import occ_arb_pkg::*;
#(
  parameter int unsigned   NREQ        = OCC_NREQ,
  parameter int unsigned   AW          = 40,
  parameter int unsigned   DW          = 64,
  parameter int unsigned   OUTSTANDING = 4,
  parameter logic [AW-1:0] BASE_ADDR   = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    resp_valid,
  output logic [DW-1:0]      resp_data,
  output logic               resp_err,
  input  logic [NREQ-1:0]    resp_ready,
  output logic [AW-1:0]      m_araddr,
  output logic [2:0]         m_arprot,
  output logic               m_arvalid,
  input  logic               m_arready,
  input  logic [DW-1:0]      m_rdata,
  input  logic [1:0]         m_rresp,
  input  logic               m_rvalid,
  output logic               m_rready,
  output logic [NREQ*32-1:0] perf_cnt
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(OUTSTANDING + 1);

  logic [NREQ_MAX-1:0] req_vec;
  rr_pick_t            pick;
  logic [IW-1:0]       win;
  logic [IW-1:0]       rr_q;
  logic [AW-1:0]       sel_addr;
  logic                slot_free;
  logic                grant;
  logic [IW-1:0]       head;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;
  logic                r_pop;

  // Grant path: pick winner, gate on a free AR slot and spare in-flight capacity.
  assign req_vec   = NREQ_MAX'(req_valid);
  assign pick      = rr_pick(req_vec, PICKW'(rr_q), NREQ);
  assign win       = IW'(pick.idx);
  assign sel_addr  = req_addr[win*AW +: AW];
  assign slot_free = ~m_arvalid | m_arready;
  assign grant     = ~rst & slot_free & ~fifo_full
                   & (32'(fifo_count) < OUTSTANDING) & pick.found;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[win] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      rr_q      <= '0;
    end else if (grant) begin
      m_arvalid <= 1'b1;
      m_araddr  <= sel_addr + BASE_ADDR;
      rr_q      <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
    end else if (m_arready) begin
      m_arvalid <= 1'b0;
    end
  end

  assign m_arprot = 3'b000;

  occ_arb_id_fifo #(
    .W     (IW),
    .DEPTH (OUTSTANDING),
    .CW    (CW)
  ) u_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (grant),
    .din   (win),
    .pop   (r_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Response path: route the R beat to the requester at the FIFO head.
  always_comb begin
    resp_valid = '0;
    if (m_rvalid && !fifo_empty) resp_valid[head] = 1'b1;
  end

  assign m_rready  = ~fifo_empty & resp_ready[head];
  assign r_pop     = m_rvalid & m_rready;
  assign resp_data = m_rdata;
  assign resp_err  = |m_rresp;

`ifdef OCC_ARB_PERF_EN
  for (genvar i = 0; i < NREQ; i++) begin : g_perf
    logic [31:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                            cnt_q <= '0;
      else if (r_pop && head == IW'(i))   cnt_q <= cnt_q + 32'd1;
    end
    assign perf_cnt[i*32 +: 32] = cnt_q;
  end
`else
  assign perf_cnt = '0;
`endif

`ifndef SYNTHESIS
  // An R beat with nothing outstanding means the slave is out of step with us.
  a_rvalid_empty : assert property (@(posedge clk) disable iff (rst) !(m_rvalid && fifo_empty));
`endif

endmodule

// File: tb/tb_occ_read_arbiter.sv
// Scoreboard bench for occ_read_arbiter: bench-side RR/AR/R models plus a latency-randomised memory slave.
module tb_occ_read_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned AW    = 40;
  localparam int unsigned DW    = 64;
  localparam int unsigned OUTST = 4;
  localparam logic [AW-1:0] BASE = 40'h12_3400_0000;
`ifdef OCC_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    resp_valid;
  logic [DW-1:0]      resp_data;
  logic               resp_err;
  logic [NREQ-1:0]    resp_ready = '0;
  logic [AW-1:0]      m_araddr;
  logic [2:0]         m_arprot;
  logic               m_arvalid;
  logic               m_arready = 1'b0;
  logic [DW-1:0]      m_rdata = '0;
  logic [1:0]         m_rresp = '0;
  logic               m_rvalid = 1'b0;
  logic               m_rready;
  logic [NREQ*32-1:0] perf_cnt;

  occ_read_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .OUTSTANDING(OUTST), .BASE_ADDR(BASE)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err), .resp_ready(resp_ready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .perf_cnt(perf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic [DW-1:0] data; logic err; } exp_t;
  typedef struct { logic [AW-1:0] addr; int due; } rd_t;

  exp_t          sb[$];
  rd_t           mq[$];
  int            grant_log[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            req_pend[NREQ];
  logic [AW-1:0] req_off[NREQ];
  int            quota[NREQ];
  int            done_cnt[NREQ];
  int            req_pct, ar_pct, rr_pct, lat_min, lat_max, off_mode, rr_exp;
  bit            mem_hold, r_pop, arv_model;
  logic [AW-1:0] addr_model;

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    return {24'hA5C3E1, a};
  endfunction

  function automatic logic mem_err(input logic [AW-1:0] a);
    return a[5:3] == 3'b111;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [AW-1:0] new_offset(input int i);
    logic [63:0] r;
    case (off_mode)
      1:       return 40'h100 + 40'(i * 64);
      2:       return 40'hF0_0000_0000 + 40'(i * 8);
      default: begin
        r = {$urandom(), $urandom()};
        return r[AW-1:0] & ~40'h7;
      end
    endcase
  endfunction

  // Decide what happens at the coming edge from the bench's own models and check the DUT against it.
  task automatic sample();
    logic [NREQ-1:0] exp_rdy, exp_rv;
    logic [AW-1:0]   ea;
    int              w;
    bit              slot, exp_mr;
    check_eq("m_arvalid", m_arvalid, arv_model);
    if (arv_model) check_eq("m_araddr", m_araddr, addr_model);
    check_eq("m_arprot", m_arprot, 0);
    exp_rdy = '0;
    w = -1;
    slot = !arv_model || m_arready;
    if (slot && sb.size() < OUTST)
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (rr_exp + k) % NREQ;
        if (w < 0 && req_valid[j]) w = j;
      end
    if (w >= 0) exp_rdy[w] = 1'b1;
    check_eq("req_ready", req_ready, exp_rdy);
    exp_rv = '0;
    exp_mr = 1'b0;
    if (sb.size() > 0) begin
      exp_mr = resp_ready[sb[0].id];
      if (m_rvalid) exp_rv[sb[0].id] = 1'b1;
    end
    check_eq("resp_valid", resp_valid, exp_rv);
    check_eq("m_rready", m_rready, exp_mr);
    if (m_rvalid && exp_mr) begin
      check_eq("resp_data", resp_data, sb[0].data);
      check_eq("resp_err", resp_err, sb[0].err);
      done_cnt[sb[0].id]++;
      sb.delete(0);
      mq.delete(0);
      r_pop = 1'b1;
    end
    if (arv_model && m_arready)
      mq.push_back('{m_araddr, cyc + $urandom_range(lat_max, lat_min)});
    if (w >= 0) begin
      ea = BASE + req_off[w];
      sb.push_back('{w, mem_data(ea), mem_err(ea)});
      req_pend[w] = 1'b0;
      rr_exp = (w + 1) % NREQ;
      grant_log.push_back(w);
      arv_model = 1'b1;
      addr_model = ea;
    end else if (m_arready) begin
      arv_model = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NREQ; i++) begin
      if (!req_pend[i] && quota[i] > 0 && $urandom_range(99, 0) < req_pct) begin
        req_pend[i] = 1'b1;
        quota[i]--;
        req_off[i] = new_offset(i);
      end
      req_valid[i] = req_pend[i];
      req_addr[i*AW +: AW] = req_off[i];
      resp_ready[i] = ($urandom_range(99, 0) < rr_pct);
    end
    m_arready = ($urandom_range(99, 0) < ar_pct);
    if (r_pop || !m_rvalid) begin
      r_pop = 1'b0;
      m_rvalid = 1'b0;
      if (!mem_hold && mq.size() > 0 && mq[0].due <= cyc) begin
        m_rvalid = 1'b1;
        m_rdata = mem_data(mq[0].addr);
        m_rresp = mem_err(mq[0].addr) ? 2'b10 : 2'b00;
      end
    end
    #4;
    sample();
  endtask

  function automatic int busy();
    int n = sb.size();
    for (int i = 0; i < NREQ; i++) n += quota[i] + int'(req_pend[i]);
    return n;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (n < budget && busy() != 0) begin
      tick();
      n++;
    end
    check_eq("drain_outstanding", sb.size(), 0);
    check_eq("drain_work_left", busy(), 0);
  endtask

  task automatic check_perf();
    for (int i = 0; i < NREQ; i++)
      check_eq("perf_cnt", perf_cnt[i*32 +: 32], PERF ? 32'(done_cnt[i]) : 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sb.delete(); mq.delete(); grant_log.delete();
    r_pop = 1'b0; m_rvalid = 1'b0; arv_model = 1'b0; addr_model = '0; rr_exp = 0;
    for (int i = 0; i < NREQ; i++) begin
      req_pend[i] = 1'b0; quota[i] = 0; done_cnt[i] = 0;
    end
    req_valid = '1;
    resp_ready = '1;
    #4;
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_m_arvalid", m_arvalid, 0);
    check_eq("rst_m_araddr", m_araddr, 0);
    check_eq("rst_m_rready", m_rready, 0);
    for (int i = 0; i < NREQ; i++) check_eq("rst_perf_cnt", perf_cnt[i*32 +: 32], 0);
    @(negedge clk);
    req_valid = '0;
    rst = 1'b0;
  endtask

  initial begin
    req_pct = 100; ar_pct = 100; rr_pct = 100; lat_min = 1; lat_max = 1;
    off_mode = 0; rr_exp = 0; mem_hold = 1'b0; r_pop = 1'b0; arv_model = 1'b0; addr_model = '0;
    do_reset();

    // All four requesting with responses held back: 0,1,2,3 then blocked at four in flight.
    mem_hold = 1'b1;
    for (int i = 0; i < NREQ; i++) quota[i] = 3;
    repeat (8) tick();
    check_eq("fill_grants", grant_log.size(), 4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++) check_eq("fill_order", grant_log[k], k);
    check_eq("fill_blocked", req_ready, 0);
    mem_hold = 1'b0;
    drain(500);

    // Single request at offset 0x100 with a fixed five-cycle memory latency.
    grant_log.delete();
    off_mode = 1; lat_min = 5; lat_max = 5;
    quota[0] = 1;
    drain(200);
    check_eq("single_grants", grant_log.size(), 1);

    // Offsets near the top of the address space wrap when the base is added.
    off_mode = 2; quota[1] = 2; quota[3] = 1;
    drain(200);

    // Head requester refuses responses: no pop, only the head sees resp_valid.
    off_mode = 0; lat_min = 1; lat_max = 1; rr_pct = 0;
    for (int i = 0; i < NREQ; i++) quota[i] = 2;
    repeat (14) tick();
    rr_pct = 100;
    drain(500);

    // Random AR backpressure, R latency and response acceptance.
    req_pct = 40; ar_pct = 50; rr_pct = 60; lat_min = 1; lat_max = 20;
    for (int i = 0; i < NREQ; i++) quota[i] = 30;
    drain(8000);
    check_perf();

    // Reset with reads in flight.
    req_pct = 100; ar_pct = 100; rr_pct = 100; lat_min = 10; lat_max = 10;
    for (int i = 0; i < NREQ; i++) quota[i] = 5;
    for (int n = 0; n < 50 && sb.size() < 3; n++) tick();
    do_reset();

    // Fresh traffic after reset: 7 reads from requester 2, 3 from requester 0.
    req_pct = 50; ar_pct = 70; rr_pct = 80; lat_min = 1; lat_max = 6; off_mode = 1;
    quota[2] = 7; quota[0] = 3;
    drain(1000);
    check_eq("perf_req2", perf_cnt[2*32 +: 32], PERF ? 32'd7 : 32'd0);
    check_eq("perf_req0", perf_cnt[0 +: 32], PERF ? 32'd3 : 32'd0);
    check_perf();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
